led_s2p_rx: RTL and testbench
=============================

Name: led_s2p_rx

Overview:
- Serial-to-parallel receiver for the LED serial link, directly downstream of the LED parallel-to-serial shifter.
- Samples a framed, LSB-first serial stream: idle high, one start bit (0), DATA_W data bits, one stop bit (1).
- Reassembles each frame into a parallel word and presents it with a one-cycle valid strobe, to drive the LED bank or a display register.
- Detects and flags framing errors.

Parameters:
- DATA_W, 16, number of data bits per frame; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- sample_en  input  1  bit-time strobe; ser_in is sampled only on cycles where this is 1
- ser_in  input  1  serial line; idle level 1
- par_out  output  DATA_W  last correctly received word; bit 0 = first data bit received
- valid  output  1  one-cycle pulse: par_out has just been updated
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- busy  output  1  high while a frame is in progress or the block is waiting for idle after an error

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset, on a clk edge with rst=1:
  - state=IDLE; shift register, bit counter, par_out = 0; valid=0, frame_err=0, busy=0.
  - rst overrides every other input, including in the middle of a frame; the partial frame is discarded.
- Cycles with sample_en=0: no state, counter or shift-register change. valid and frame_err still deassert after their one pulse cycle.
- State machine (transitions only on cycles with sample_en=1):
  - IDLE: ser_in=0 -> DATA, counter=0. ser_in=1 -> stay in IDLE.
  - DATA:
    - shreg <= {ser_in, shreg[DATA_W-1:1]} (LSB-first reassembly); counter++.
    - When the counter was DATA_W-1 before the increment -> STOP.
    - Exactly DATA_W samples are taken in DATA.
  - STOP, ser_in=1: par_out <= shreg; valid=1 for the next cycle only; -> IDLE.
  - STOP, ser_in=0: par_out unchanged; frame_err=1 for the next cycle only; -> WAIT_IDLE.
  - WAIT_IDLE: ser_in=1 -> IDLE. ser_in=0 -> stay. A low line after an error is never taken as a start bit.
- busy = 1 in DATA, STOP and WAIT_IDLE; 0 in IDLE. Registered, so it changes on the same edge as the state.
- Latency: valid (and the updated par_out) is visible the clock after the edge that samples the stop bit. par_out and valid change on the same edge.
- Back-to-back frames: a start bit sampled in IDLE on the sample immediately after the stop bit is accepted; no idle gap is required.
- valid and frame_err are never high together.
- par_out holds its value until the next good frame or reset.
- Counter width: clog2(DATA_W)+1 bits; no wrap inside a frame.
- Sampling model: with sample_en tied to 1, one bit per clock. This matches an upstream shifter that moves one bit per clock.

Test Plan:
- Reset, sample_en=1, ser_in=1 for 20 cycles -> busy=0, valid=0, frame_err=0, par_out=0x0000 throughout.
- sample_en=1; send start 0, data 0xA5C3 LSB-first (1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1), stop 1 -> valid pulses exactly once, 1 cycle after the stop sample; par_out=0xA5C3; busy high for 17 cycles.
- Same frame 0xA5C3, but sample_en=1 only every 4th cycle -> identical result; valid still 1 cycle wide; par_out unchanged during the gaps.
- Two frames back-to-back, 0x0001 then 0xFFFE, no idle gap -> two valid pulses 18 sample-cycles apart; par_out 0x0001 then 0xFFFE.
- Good frame 0x1234 first; then frame 0xBEEF with stop bit 0; line held 0 for 5 samples, then 1 -> frame_err one pulse; par_out stays 0x1234; busy=1 until the first high sample; no spurious frame starts.
- Assert rst after 8 data bits of a frame; then send a full 0x00FF frame -> par_out=0 after reset, no valid from the aborted frame; next valid shows par_out=0x00FF.

Source files
------------

// File: rtl/led_s2p_rx.sv
// LED serial link receiver: framed LSB-first stream (start 0, DATA_W bits, stop 1)
// reassembled into a parallel word with one-cycle valid and frame-error strobes.
module led_s2p_rx #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_en,
   input  logic              ser_in,
   output logic [DATA_W-1:0] par_out,
   output logic              valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {IDLE, DATA, STOP, WAIT_IDLE} state_t;

   state_t                  r_state, w_state_nxt;
   logic signed [DATA_W-1:0] r_shreg, w_shreg_nxt;
   logic [DATA_W-1:0]       r_par, w_par_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic                    r_valid, w_valid_nxt;
   logic                    r_ferr, w_ferr_nxt;
   logic                    r_busy, w_busy_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_shreg <= '0;
         r_par   <= '0;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_par   <= w_par_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_par_nxt   = r_par;
      w_cnt_nxt   = r_cnt;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      if (sample_en) begin
         unique case (r_state)
            IDLE: begin
               if (!ser_in) begin
                  w_state_nxt = DATA;
                  w_cnt_nxt   = '0;
               end
            end
            DATA: begin
               // First bit received ends up in bit 0 after DATA_W shifts.
               w_shreg_nxt = {ser_in, r_shreg[DATA_W-1:1]};
               w_cnt_nxt   = r_cnt + 1'b1;
               if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = STOP;
            end
            STOP: begin
               if (ser_in) begin
                  w_par_nxt   = r_shreg;
                  w_valid_nxt = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_state_nxt = WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (ser_in) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   assign par_out   = r_par;
   assign valid     = r_valid;
   assign frame_err = r_ferr;
   assign busy      = r_busy;

endmodule

// File: tb/tb_led_s2p_rx.sv
// Directed bench for led_s2p_rx: driver pushes expected words/errors to queues,
// a negedge monitor pops and compares them, plus busy and par_out hold models.
module tb_led_s2p_rx;

   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              sample_en = 1'b0;
   logic              ser_in = 1'b1;
   logic [DATA_W-1:0] par_out;
   logic              valid;
   logic              frame_err;
   logic              busy;

   led_s2p_rx #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .ser_in    (ser_in),
      .par_out   (par_out),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] word;
      int                cyc;
   } exp_t;

   exp_t              exp_q[$];
   int                ferr_q[$];
   int                errors = 0;
   int                checks = 0;
   int                cyc = 0;
   logic              exp_busy = 1'b0;
   logic [DATA_W-1:0] last_good = '0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Monitor: compares outputs against the queues and models away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         last_good = '0;
      end else begin
         chk("busy", {31'd0, busy}, {31'd0, exp_busy});
         chk("valid_and_ferr", {31'd0, valid & frame_err}, 32'd0);
         if (valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("par_out", {16'd0, par_out}, {16'd0, e.word});
               chk("valid_latency", cyc, e.cyc);
               last_good = e.word;
            end
         end else begin
            chk("par_hold", {16'd0, par_out}, {16'd0, last_good});
         end
         if (frame_err) begin
            if (ferr_q.size() == 0) begin
               chk("spurious_frame_err", 32'd1, 32'd0);
            end else begin
               chk("ferr_latency", cyc, ferr_q.pop_front());
            end
         end
      end
   end

   task automatic sample(input logic b);
      ser_in    = b;
      sample_en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         sample_en = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      ser_in    = 1'b1;
      sample_en = 1'b1;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop, input int g);
      exp_t e;
      sample(1'b0);
      exp_busy = 1'b1;
      gap(g);
      for (int i = 0; i < DATA_W; i++) begin
         sample(word[i]);
         gap(g);
      end
      sample(stop);
      if (stop) begin
         e.word = word;
         e.cyc  = cyc;
         exp_q.push_back(e);
         exp_busy = 1'b0;
      end else begin
         ferr_q.push_back(cyc);
      end
      gap(g);
   endtask

   initial begin
      // Reset, then idle line for 20 cycles.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle(20);

      send_frame(16'hA5C3, 1'b1, 0);
      idle(3);

      send_frame(16'hA5C3, 1'b1, 3);
      idle(3);

      send_frame(16'h0001, 1'b1, 0);
      send_frame(16'hFFFE, 1'b1, 0);
      idle(3);

      // Bad stop bit, line held low, then released.
      send_frame(16'h1234, 1'b1, 0);
      send_frame(16'hBEEF, 1'b0, 0);
      repeat (5) sample(1'b0);
      sample(1'b1);
      exp_busy = 1'b0;
      idle(4);

      // Abort mid-frame with reset.
      sample(1'b0);
      exp_busy = 1'b1;
      for (int i = 0; i < 8; i++) sample(i[0]);
      ser_in   = 1'b1;
      rst      = 1'b1;
      exp_busy = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);
      send_frame(16'h00FF, 1'b1, 0);
      idle(4);

      chk("pending_valid", exp_q.size(), 32'd0);
      chk("pending_frame_err", ferr_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
